// File: rtl/pb_input_frontend.sv
// rtl/pb_input_frontend.sv - pushbutton synchroniser, debouncer, edge strobes and last-key encoder
// Optional auto-repeat of key_strobe is enabled by defining PB_AUTOREPEAT_EN.
module pb_input_frontend #(
    parameter int NUM_PB        = 21,
    parameter int DB_CYCLES     = 10000,
    parameter int DB_W          = 16,
    parameter int REPEAT_DELAY  = 5000000,
    parameter int REPEAT_PERIOD = 1000000,
    localparam int KW           = (NUM_PB > 1) ? $clog2(NUM_PB) : 1
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              cs,
    input  logic [NUM_PB-1:0] pb_raw,
    output logic [NUM_PB-1:0] pb_level,
    output logic [NUM_PB-1:0] pb_rise,
    output logic              key_valid,
    output logic              key_strobe,
    output logic [KW-1:0]     key_idx
);

    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

    logic              rst;
    logic [NUM_PB-1:0] s1_q, s1_d, s2_q, s2_d;
    logic [NUM_PB-1:0] level_q, level_d, rise_q, rise_d;
    logic [DB_W-1:0]   cnt_q [NUM_PB];
    logic [DB_W-1:0]   cnt_d [NUM_PB];
    logic              key_valid_q, key_valid_d;
    logic              key_strobe_q, key_strobe_d;
    logic [KW-1:0]     key_idx_q, key_idx_d;
    logic [KW-1:0]     low_idx;

    assign rst = !nrst || !cs;

    // Counter only runs while the synchronised pin disagrees with the accepted level.
    always_comb begin
        s1_d    = pb_raw;
        s2_d    = s1_q;
        level_d = level_q;
        for (int i = 0; i < NUM_PB; i++) begin
            cnt_d[i] = '0;
            if (s2_q[i] != level_q[i]) begin
                if (cnt_q[i] == DB_LAST) begin
                    level_d[i] = s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
        rise_d      = level_d & ~level_q;
        key_valid_d = |level_q;
    end

    always_comb begin
        low_idx = '0;
        for (int i = NUM_PB - 1; i >= 0; i--) begin
            if (rise_q[i]) begin
                low_idx = KW'(i);
            end
        end
    end

`ifdef PB_AUTOREPEAT_EN
    logic [31:0] rpt_cnt_q, rpt_cnt_d;
    logic        rpt_first_q, rpt_first_d;
    logic        rpt_active_q, rpt_active_d;
    logic        key_held;
    logic [31:0] rpt_last;

    always_comb begin
        key_held = 1'b0;
        for (int i = 0; i < NUM_PB; i++) begin
            if (key_idx_q == KW'(i)) begin
                key_held = level_q[i];
            end
        end
        rpt_last = rpt_first_q ? 32'(REPEAT_DELAY - 1) : 32'(REPEAT_PERIOD - 1);
    end

    // A fresh rise always wins over a due repeat and restarts the delay for the new key.
    always_comb begin
        key_strobe_d = 1'b0;
        key_idx_d    = key_idx_q;
        rpt_cnt_d    = rpt_cnt_q;
        rpt_first_d  = rpt_first_q;
        rpt_active_d = rpt_active_q;
        if (|rise_q) begin
            key_strobe_d = 1'b1;
            key_idx_d    = low_idx;
            rpt_cnt_d    = '0;
            rpt_first_d  = 1'b1;
            rpt_active_d = 1'b1;
        end else if (!key_held) begin
            rpt_active_d = 1'b0;
            rpt_cnt_d    = '0;
        end else if (rpt_active_q) begin
            if (rpt_cnt_q == rpt_last) begin
                key_strobe_d = 1'b1;
                rpt_cnt_d    = '0;
                rpt_first_d  = 1'b0;
            end else begin
                rpt_cnt_d = rpt_cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rpt_cnt_q    <= '0;
            rpt_first_q  <= 1'b0;
            rpt_active_q <= 1'b0;
        end else begin
            rpt_cnt_q    <= rpt_cnt_d;
            rpt_first_q  <= rpt_first_d;
            rpt_active_q <= rpt_active_d;
        end
    end
`else
    always_comb begin
        key_strobe_d = |rise_q;
        key_idx_d    = (|rise_q) ? low_idx : key_idx_q;
    end

    // Repeat timing parameters are accepted for a uniform interface but have no effect here.
    if (REPEAT_DELAY < 0 || REPEAT_PERIOD < 0) begin : g_repeat_unused
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q         <= '0;
            s2_q         <= '0;
            level_q      <= '0;
            rise_q       <= '0;
            key_valid_q  <= 1'b0;
            key_strobe_q <= 1'b0;
            key_idx_q    <= '0;
            for (int i = 0; i < NUM_PB; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            s1_q         <= s1_d;
            s2_q         <= s2_d;
            level_q      <= level_d;
            rise_q       <= rise_d;
            key_valid_q  <= key_valid_d;
            key_strobe_q <= key_strobe_d;
            key_idx_q    <= key_idx_d;
            for (int i = 0; i < NUM_PB; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign pb_level   = level_q;
    assign pb_rise    = rise_q;
    assign key_valid  = key_valid_q;
    assign key_strobe = key_strobe_q;
    assign key_idx    = key_idx_q;

endmodule

// File: tb/tb_pb_input_frontend.sv
// tb/tb_pb_input_frontend.sv - self-checking bench for pb_input_frontend
module tb_pb_input_frontend;

    localparam int N   = 21;
    localparam int DB  = 4;
    localparam int RD  = 20;
    localparam int RP  = 8;

    logic          clk = 1'b0;
    logic          nrst;
    logic          cs;
    logic [N-1:0]  pb_raw;
    logic [N-1:0]  pb_level;
    logic [N-1:0]  pb_rise;
    logic          key_valid;
    logic          key_strobe;
    logic [4:0]    key_idx;

    pb_input_frontend #(
        .NUM_PB(N), .DB_CYCLES(DB), .DB_W(3),
        .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) dut (
        .clk(clk), .nrst(nrst), .cs(cs), .pb_raw(pb_raw),
        .pb_level(pb_level), .pb_rise(pb_rise), .key_valid(key_valid),
        .key_strobe(key_strobe), .key_idx(key_idx)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference model: behaviour stated as "disagreement must persist DB edges"
    logic [N-1:0] m_s1 = '0, m_s2 = '0, m_lvl = '0, m_rise = '0;
    logic         m_kv = 0, m_st = 0;
    logic [4:0]   m_idx = '0;
    int           m_run [N];
    int           m_since = 0, m_target = 0;
    bit           m_active = 0;

    task automatic model_edge();
        logic [N-1:0] lvl_old, rise_old;
        if (!nrst || !cs) begin
            m_s1 = '0; m_s2 = '0; m_lvl = '0; m_rise = '0;
            m_kv = 0; m_st = 0; m_idx = '0;
            for (int i = 0; i < N; i++) m_run[i] = 0;
            m_since = 0; m_target = 0; m_active = 0;
        end else begin
            lvl_old  = m_lvl;
            rise_old = m_rise;
            for (int i = 0; i < N; i++) begin
                m_run[i] = (m_s2[i] != lvl_old[i]) ? m_run[i] + 1 : 0;
                if (m_run[i] == DB) begin
                    m_lvl[i] = m_s2[i];
                    m_run[i] = 0;
                end
            end
            m_s2   = m_s1;
            m_s1   = pb_raw;
            m_rise = m_lvl & ~lvl_old;
            m_kv   = |lvl_old;
            m_st   = 0;
            if (rise_old != '0) begin
                m_st = 1;
                for (int i = 0; i < N; i++) begin
                    if (rise_old[i]) begin
                        m_idx = 5'(i);
                        break;
                    end
                end
                m_since = 0; m_target = RD; m_active = 1;
            end
`ifdef PB_AUTOREPEAT_EN
            else if (!lvl_old[m_idx]) begin
                m_active = 0;
            end else if (m_active) begin
                m_since++;
                if (m_since == m_target) begin
                    m_st = 1; m_since = 0; m_target = RP;
                end
            end
`endif
        end
    endtask

    function automatic logic [63:0] dut_vec();
        return {15'b0, pb_level, pb_rise, key_valid, key_strobe, key_idx};
    endfunction

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("model", dut_vec(), {15'b0, m_lvl, m_rise, m_kv, m_st, m_idx});
    endtask

    typedef struct {
        string        name;
        logic [N-1:0] raw;
        logic         cs;
        logic         nrst;
        int           n;
        logic [N-1:0] lvl;
        logic [N-1:0] rise;
        logic         kv;
        logic         st;
        logic [4:0]   idx;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input string nm, input logic [N-1:0] raw, input logic c, input logic r,
                       input int n, input logic [N-1:0] lvl, input logic [N-1:0] rise,
                       input logic kv, input logic st, input logic [4:0] idx);
        vec_t v;
        v.name = nm; v.raw = raw; v.cs = c; v.nrst = r; v.n = n;
        v.lvl = lvl; v.rise = rise; v.kv = kv; v.st = st; v.idx = idx;
        vecs.push_back(v);
    endtask

    initial begin
        logic [N-1:0] all_on, b3, b5, b7, b9, b12, b17, l0, r1, r2;
        logic [63:0]  mask, exp_mask;
        int           strobes;
        bit           found;

        all_on = '1;
        b3 = 21'(1) << 3;  b5 = 21'(1) << 5;  b7 = 21'(1) << 7;
        b9 = 21'(1) << 9;  b12 = 21'(1) << 12; b17 = 21'(1) << 17;
        l0 = b3 | b5 | b17; r1 = l0 | b9; r2 = r1 | b12;

        add("reset",       all_on, 1, 0, 2, '0, '0, 0, 0, 0);
        add("rst_rel_e5",  all_on, 1, 1, 5, '0, '0, 0, 0, 0);
        add("rst_rel_e6",  all_on, 1, 1, 1, all_on, all_on, 0, 0, 0);
        add("rst_rel_e7",  all_on, 1, 1, 1, all_on, '0, 1, 1, 0);
        add("drop_all_e5", '0, 1, 1, 5, all_on, '0, 1, 0, 0);
        add("drop_all_e6", '0, 1, 1, 1, '0, '0, 1, 0, 0);
        add("drop_all_e7", '0, 1, 1, 1, '0, '0, 0, 0, 0);
        add("bounce_1a",   b5, 1, 1, 1, '0, '0, 0, 0, 0);
        add("bounce_0a",   '0, 1, 1, 1, '0, '0, 0, 0, 0);
        add("bounce_1b",   b5, 1, 1, 1, '0, '0, 0, 0, 0);
        add("bounce_0b",   '0, 1, 1, 1, '0, '0, 0, 0, 0);
        add("bounce_e5",   b5, 1, 1, 5, '0, '0, 0, 0, 0);
        add("bounce_e6",   b5, 1, 1, 1, b5, b5, 0, 0, 0);
        add("bounce_e7",   b5, 1, 1, 1, b5, '0, 1, 1, 5);
        add("bounce_e8",   b5, 1, 1, 1, b5, '0, 1, 0, 5);
        add("simul_e5",    l0, 1, 1, 5, b5, '0, 1, 0, 5);
        add("simul_e6",    l0, 1, 1, 1, l0, b3 | b17, 1, 0, 5);
        add("simul_e7",    l0, 1, 1, 1, l0, '0, 1, 1, 3);
        add("simul_e8",    l0, 1, 1, 1, l0, '0, 1, 0, 3);
        add("b9_e5",       r1, 1, 1, 5, l0, '0, 1, 0, 3);
        add("b9_e6",       r1, 1, 1, 1, r1, b9, 1, 0, 3);
        add("b9_e7",       r1, 1, 1, 1, r1, '0, 1, 1, 9);
        add("cs_pre",      r2, 1, 1, 3, r1, '0, 1, 0, 9);
        add("cs_low",      r2, 0, 1, 1, '0, '0, 0, 0, 0);
        add("cs_e5",       r2, 1, 1, 5, '0, '0, 0, 0, 0);
        add("cs_e6",       r2, 1, 1, 1, r2, r2, 0, 0, 0);
        add("cs_e7",       r2, 1, 1, 1, r2, '0, 1, 1, 3);
        add("release_e5",  '0, 1, 1, 5, r2, '0, 1, 0, 3);
        add("release_e6",  '0, 1, 1, 1, '0, '0, 1, 0, 3);
        add("release_e7",  '0, 1, 1, 1, '0, '0, 0, 0, 3);
        add("hold7_e6",    b7, 1, 1, 6, b7, b7, 0, 0, 3);
        add("hold7_e7",    b7, 1, 1, 1, b7, '0, 1, 1, 7);

        nrst = 0; cs = 1; pb_raw = all_on;
        for (int i = 0; i < N; i++) m_run[i] = 0;

        foreach (vecs[k]) begin
            nrst = vecs[k].nrst; cs = vecs[k].cs; pb_raw = vecs[k].raw;
            repeat (vecs[k].n) step();
            check(vecs[k].name, dut_vec(),
                  {15'b0, vecs[k].lvl, vecs[k].rise, vecs[k].kv, vecs[k].st, vecs[k].idx});
        end

        // Key 7 held: record strobe offsets after its press strobe
        mask = '0;
        for (int k = 1; k <= 50; k++) begin
            step();
            if (key_strobe) mask[k] = 1'b1;
        end
`ifdef PB_AUTOREPEAT_EN
        exp_mask = (64'(1) << 20) | (64'(1) << 28) | (64'(1) << 36) | (64'(1) << 44);
`else
        exp_mask = '0;
`endif
        check("repeat_pattern", mask, exp_mask);
        check("repeat_idx", 64'(key_idx), 64'd7);

        pb_raw = '0;
        found = 0;
        for (int k = 0; k < 20 && !found; k++) begin
            step();
            if (pb_level == '0) found = 1;
        end
        check("release7_level_drop", 64'(found), 64'd1);
        strobes = 0;
        for (int k = 0; k < 40; k++) begin
            step();
            if (key_strobe) strobes++;
        end
        check("release7_no_strobe", 64'(strobes), 64'd0);
        check("release7_idx_held", 64'(key_idx), 64'd7);

        // Randomised traffic against the model
        for (int k = 0; k < 1500; k++) begin
            int b;
            nrst = ($urandom_range(299, 0) != 0);
            cs   = ($urandom_range(199, 0) != 0);
            if ($urandom_range(5, 0) == 0) begin
                b = $urandom_range(N - 1, 0);
                pb_raw[b] = ~pb_raw[b];
            end
            if ($urandom_range(9, 0) == 0) begin
                b = $urandom_range(N - 1, 0);
                pb_raw[b] = ~pb_raw[b];
                step();
                pb_raw[b] = ~pb_raw[b];
            end
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pb_input_frontend.md
# pb_input_frontend

Parametrised pushbutton front end between the breakout GPIO pins and the synthesiser core. It replaces the raw pass-through of button pins with per-channel synchronisers, debouncing and rising-edge strobes, plus a registered "last key pressed" encoder. An optional auto-repeat feature is available. The chip-select gating of reset is folded into the block, so the core sees clean, reset-aligned key events.

## Interface
Parameters:
- NUM_PB, 21, number of button channels (1..64).
- DB_CYCLES, 10000, stable cycles required before a level change is accepted (≥1). At 10 MHz this is 1 ms.
- DB_W, 16, width of each debounce counter. Must satisfy DB_CYCLES ≤ 2^DB_W.
- REPEAT_DELAY, 5000000, cycles from a key strobe to the first auto-repeat. Used only with PB_AUTOREPEAT_EN.
- REPEAT_PERIOD, 1000000, cycles between later auto-repeats. Used only with PB_AUTOREPEAT_EN.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- nrst  in  1  reset, synchronous, active-low.
- cs  in  1  chip select. 1 = block enabled; 0 = synchronous clear, identical in effect to nrst=0.
- pb_raw  in  NUM_PB  asynchronous button pins, active-high.
- pb_level  out  NUM_PB  debounced button levels.
- pb_rise  out  NUM_PB  one-cycle strobe per channel when its pb_level goes 0→1.
- key_valid  out  1  registered OR of pb_level.
- key_strobe  out  1  one-cycle key event pulse.
- key_idx  out  clog2(NUM_PB) (min 1)  channel index of the most recent key event.

## Operation
- Effective reset is rst = !nrst || !cs, sampled on the clock edge.
- Under rst, every register clears:
  - sync stages, counters, pb_level, pb_rise, key_valid, key_strobe, key_idx all = 0
  - repeat state is cleared.
- Synchroniser: two flops per channel, s1 <= pb_raw, s2 <= s1. No logic between s1 and s2.
- Debounce, per channel:
  - If s2 == pb_level: cnt <= 0.
  - Else if cnt == DB_CYCLES-1: pb_level <= s2 and cnt <= 0.
  - Else: cnt <= cnt+1.
  - cnt saturates by construction and never wraps.
- pb_rise[i] is registered and high for exactly the one cycle in which pb_level[i] first reads 1. Falling edges produce no strobe.
- key_valid <= |pb_level. It lags pb_level by one cycle.
- Key encoder: if |pb_rise:
  - key_strobe <= 1.
  - key_idx <= lowest set index of pb_rise.
  - Otherwise key_strobe <= 0 and key_idx holds.
- Simultaneous rises: lowest index wins key_idx and only one key_strobe is issued. pb_rise still shows every channel that rose.
- A new press on a higher index while a lower one is held still updates key_idx. key_idx tracks the most recent press, not a priority among held keys.
- Release of all keys leaves key_idx at its last value. key_valid drops to 0.

## Timing
- A pb_raw change that stays stable reaches pb_level on clock edge DB_CYCLES+2, counting the first edge that samples it as edge 1.
- pb_rise is asserted on that same edge.
- key_strobe and key_idx update one edge later. Total press latency is DB_CYCLES+3 edges.
- Any s2 mismatch that lasts fewer than DB_CYCLES cycles clears the counter and leaves pb_level unchanged.
- A pulse at the exact boundary (stable for DB_CYCLES cycles at s2) is accepted.
- cs or nrst deasserted mid-debounce discards all partial counts. After release of reset, a held button takes the full DB_CYCLES+2 edges again.
- All outputs are registered. No combinational path runs from pb_raw to any output.

## Configuration
- Macro: PB_AUTOREPEAT_EN.
- Defined, auto-repeat is enabled:
  - After any key_strobe, a repeat counter starts for channel key_idx.
  - If pb_level[key_idx] is still 1 after REPEAT_DELAY cycles, key_strobe pulses again with key_idx unchanged.
  - Further pulses follow every REPEAT_PERIOD cycles while the key is held.
  - Release of that channel stops repeating.
  - A new pb_rise restarts the repeat timing for the new key_idx.
  - A new rise and a repeat in the same cycle produce one pulse, with the new key's index.
- Undefined:
  - No repeat counter is synthesised.
  - key_strobe fires only on pb_rise.
  - REPEAT_DELAY and REPEAT_PERIOD are ignored.

## Test plan
- Use NUM_PB=21 and DB_CYCLES=4 for all scenarios. Scenario 6 also uses REPEAT_DELAY=20 and REPEAT_PERIOD=8.
- Reset: nrst=0 for 2 cycles while pb_raw=all-ones → all outputs 0. After release, pb_level=21'h1FFFFF on edge 6, and key_strobe with key_idx=0 on edge 7.
- Bounce: pb_raw[5] toggles 1,0,1,0 on consecutive cycles, then holds 1 → no pb_level change during toggling. pb_level[5] rises exactly 6 edges after the final 0→1, pb_rise[5] is a single-cycle pulse, and key_idx=5.
- Simultaneous: pb_raw[3] and pb_raw[17] rise on the same cycle → pb_rise=bits 3 and 17, one key_strobe, key_idx=3. Then pb_raw[9] rises → key_idx=9 while key_valid stays 1.
- cs gating: cs=0 for 1 cycle while pb_raw[12] has been high for 3 cycles → counter cleared. pb_level[12] rises 6 edges after cs returns to 1.
- Release: drop all buttons → pb_level clears after 6 edges, key_valid=0 one edge later, key_idx unchanged, no key_strobe.
- PB_AUTOREPEAT_EN: hold pb_raw[7] → key_strobe at press latency, then 20 cycles later, then every 8 cycles. Releasing the button stops the pulses. The macro-off build shows exactly one pulse.
